// File: rtl/mem_rf_if.sv
// Bus bundle for mem_rf: one masked write port, NRD read ports, and the clear-sweep status.
// The master drives the write and read requests; the slave returns registered read data and busy.
interface mem_rf_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(DEPTH);

    logic                 we;
    logic [AW-1:0]        wa;
    logic [WIDTH-1:0]     wd;
    logic [WIDTH-1:0]     wm;
    logic [NRD-1:0]       re;
    logic [NRD*AW-1:0]    ra;
    logic [NRD*WIDTH-1:0] rd;
    logic                 busy;

    modport master (output we, wa, wd, wm, re, ra, input rd, busy);
    modport slave  (input we, wa, wd, wm, re, ra, output rd, busy);
endinterface

// File: rtl/mem_rf.sv
// Register file with one masked write port, NRD registered read ports and a post-reset clear sweep.
// BYPASS selects whether a same-edge read of the write address sees the new or the old word.
module mem_rf #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic     clk,
    input  logic     rst,
    mem_rf_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {CLEAR, READY} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_p1 [NRD];
    logic [WIDTH-1:0] merged;
    logic             arr_we;
    logic [AW-1:0]    arr_wa;
    logic [WIDTH-1:0] arr_wd;

    // Word that a masked write would leave in the addressed entry.
    assign merged = (mem[bus.wa] & ~bus.wm) | (bus.wd & bus.wm);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        arr_we  = 1'b0;
        arr_wa  = bus.wa;
        arr_wd  = merged;
        case (state_q)
            CLEAR: begin
                // The sweep owns the write port; external writes are dropped.
                arr_we = 1'b1;
                arr_wa = cnt_q;
                arr_wd = '0;
                cnt_d  = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1))
                    state_d = READY;
            end
            READY:   arr_we = bus.we;
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arr_we)
            mem[arr_wa] <= arr_wd;
    end

    // Stage p1: registered read ports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NRD; i++)
                rd_p1[i] <= '0;
        end else begin
            for (int i = 0; i < NRD; i++) begin
                if (bus.re[i]) begin
                    if (state_q == CLEAR)
                        rd_p1[i] <= '0;
                    else if ((BYPASS != 0) && bus.we && (bus.ra[i*AW +: AW] == bus.wa))
                        rd_p1[i] <= merged;
                    else
                        rd_p1[i] <= mem[bus.ra[i*AW +: AW]];
                end
            end
        end
    end

    always_comb begin
        bus.rd = '0;
        for (int i = 0; i < NRD; i++)
            bus.rd[i*WIDTH +: WIDTH] = rd_p1[i];
    end

    assign bus.busy = (state_q == CLEAR);
endmodule

// File: tb/tb_mem_rf.sv
// Bench for mem_rf: drives a BYPASS=1 and a BYPASS=0 instance with identical traffic and
// compares both against an array-based model of the register file, plus directed scenarios.
module tb_mem_rf;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int NRD   = 2;
    localparam int AW    = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                 we;
    logic [AW-1:0]        wa;
    logic [WIDTH-1:0]     wd;
    logic [WIDTH-1:0]     wm;
    logic [NRD-1:0]       re;
    logic [NRD*AW-1:0]    ra;

    mem_rf_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD)) b1 ();
    mem_rf_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD)) b0 ();

    assign b1.we = we;  assign b1.wa = wa;  assign b1.wd = wd;
    assign b1.wm = wm;  assign b1.re = re;  assign b1.ra = ra;
    assign b0.we = we;  assign b0.wa = wa;  assign b0.wd = wd;
    assign b0.wm = wm;  assign b0.re = re;  assign b0.ra = ra;

    mem_rf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD), .BYPASS(1)) dut1 (
        .clk(clk), .rst(rst), .bus(b1.slave));
    mem_rf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD), .BYPASS(0)) dut0 (
        .clk(clk), .rst(rst), .bus(b0.slave));

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: array contents, remaining sweep cycles, expected read registers.
    logic [WIDTH-1:0] m [DEPTH];
    int               sweep_left = DEPTH;
    logic [WIDTH-1:0] e1 [NRD];
    logic [WIDTH-1:0] e0 [NRD];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_edge();
        logic [WIDTH-1:0] nw;
        logic [AW-1:0]    a;
        if (rst) begin
            sweep_left = DEPTH;
            for (int i = 0; i < NRD; i++) begin e1[i] = '0; e0[i] = '0; end
        end else if (sweep_left > 0) begin
            m[DEPTH - sweep_left] = '0;
            for (int i = 0; i < NRD; i++)
                if (re[i]) begin e1[i] = '0; e0[i] = '0; end
            sweep_left--;
        end else begin
            nw = (m[wa] & ~wm) | (wd & wm);
            for (int i = 0; i < NRD; i++) begin
                a = ra[i*AW +: AW];
                if (re[i]) begin
                    e0[i] = m[a];
                    e1[i] = (we && a == wa) ? nw : m[a];
                end
            end
            if (we) m[wa] = nw;
        end
    endtask

    // One clock: advance the model, let the DUTs take the edge, compare just after it.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("busy_b1", b1.busy, sweep_left > 0);
        check("busy_b0", b0.busy, sweep_left > 0);
        for (int i = 0; i < NRD; i++) begin
            check("rd_b1", b1.rd[i*WIDTH +: WIDTH], e1[i]);
            check("rd_b0", b0.rd[i*WIDTH +: WIDTH], e0[i]);
        end
    endtask

    task automatic drive(input logic we_, input logic [AW-1:0] wa_, input logic [WIDTH-1:0] wd_,
                         input logic [WIDTH-1:0] wm_, input logic [NRD-1:0] re_,
                         input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        we = we_; wa = wa_; wd = wd_; wm = wm_; re = re_; ra = {ra1, ra0};
        step();
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, '0, '0, '0);
    endtask

    task automatic async_reset_check(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_rd_b1"}, b1.rd, '0);
        check({tag, "_rd_b0"}, b0.rd, '0);
        check({tag, "_busy"}, b1.busy & b0.busy, 1'b1);
        step();
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        we = 1'b0; wa = '0; wd = '0; wm = '0; re = '0; ra = '0;
        #1;
        check("rst_rd", b1.rd | b0.rd, '0);
        check("rst_busy", b1.busy & b0.busy, 1'b1);
        step();
        #1 rst = 1'b0;

        // Sweep with a write attempt and port-0 reads; busy must last exactly DEPTH edges.
        cnt = 0;
        for (int k = 0; k < DEPTH + 4 && b1.busy; k++) begin
            drive(1'b1, 2'd0, 8'h77, 8'hFF, 2'b01, 2'd0, 2'd0);
            check("sweep_rd0", b1.rd[7:0], 8'h00);
            cnt++;
        end
        check("sweep_len", cnt, DEPTH);

        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b0, '0, '0, '0, 2'b01, AW'(a), '0);
            check("cleared", b1.rd[7:0], 8'h00);
        end

        // Full write, dual read, then hold.
        drive(1'b1, 2'd2, 8'h6F, 8'hFF, 2'b00, '0, '0);
        drive(1'b0, '0, '0, '0, 2'b11, 2'd2, 2'd2);
        check("wr_rd0", b1.rd[7:0], 8'h6F);
        check("wr_rd1", b1.rd[15:8], 8'h6F);
        for (int k = 0; k < 3; k++) idle();
        check("hold_rd0", b0.rd[7:0], 8'h6F);
        check("hold_rd1", b0.rd[15:8], 8'h6F);

        // Masked write.
        drive(1'b1, 2'd1, 8'hAA, 8'hFF, 2'b00, '0, '0);
        drive(1'b1, 2'd1, 8'h55, 8'h0F, 2'b00, '0, '0);
        drive(1'b0, '0, '0, '0, 2'b01, 2'd1, '0);
        check("mask", b1.rd[7:0], 8'hA5);

        // Collision on address 3.
        drive(1'b1, 2'd3, 8'h11, 8'hFF, 2'b00, '0, '0);
        drive(1'b1, 2'd3, 8'h22, 8'hFF, 2'b01, 2'd3, '0);
        check("coll_byp1", b1.rd[7:0], 8'h22);
        check("coll_byp0", b0.rd[7:0], 8'h11);
        drive(1'b0, '0, '0, '0, 2'b01, 2'd3, '0);
        check("coll_after", b0.rd[7:0], 8'h22);

        // Randomised traffic, biased towards collisions and boundary masks.
        for (int k = 0; k < 300; k++) begin
            logic [WIDTH-1:0] mk;
            case ($urandom_range(0, 3))
                0: mk = 8'h00;
                1: mk = 8'hFF;
                default: mk = WIDTH'($urandom);
            endcase
            drive(1'($urandom), AW'($urandom), WIDTH'($urandom), mk,
                  NRD'($urandom), AW'($urandom), AW'($urandom));
        end

        // Reset from READY with live read data, then again two cycles into the sweep.
        drive(1'b1, 2'd0, 8'hC3, 8'hFF, 2'b00, '0, '0);
        drive(1'b0, '0, '0, '0, 2'b11, 2'd0, 2'd0);
        async_reset_check("rst_ready");
        idle();
        idle();
        async_reset_check("rst_sweep");
        cnt = 0;
        for (int k = 0; k < DEPTH + 4 && b1.busy; k++) begin
            idle();
            cnt++;
        end
        check("resweep_len", cnt, DEPTH);
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b0, '0, '0, '0, 2'b11, AW'(a), AW'(DEPTH - 1 - a));
            check("recleared", b1.rd, '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_rf.md
Name: mem_rf

Overview:
- Parametrised successor to the team's 4x8 single-write scratch memory.
- Generalised in data width, depth and read-port count.
- Adds registered reads, a per-bit write mask, optional read-during-write bypass, and a hardware clear sweep after reset.
- Used as the register file and scratch store in the datapath exercises. The block is drop-in where one write port plus NRD independent read ports are needed.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 4, number of entries; must be a power of two and >=2.
- AW, $clog2(DEPTH), address width; derived, never overridden.
- NRD, 2, number of independent read ports (>=1).
- BYPASS, 1, selects the same-cycle read/write collision mode. 1 = the read returns the newly written data. 0 = the read returns the old data.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- we  input  1  write enable.
- wa  input  AW  write address.
- wd  input  WIDTH  write data.
- wm  input  WIDTH  write bit mask; 1 = the bit is written.
- re  input  NRD  read enables; bit i belongs to port i.
- ra  input  NRD*AW  read addresses; port i uses ra[i*AW +: AW].
- rd  output  NRD*WIDTH  registered read data; port i drives rd[i*WIDTH +: WIDTH].
- busy  output  1  high while the clear sweep runs.

Behaviour:
- Reset: while rst is high, asynchronously force rd = 0, busy = 1, state = CLEAR, sweep counter = 0. Array contents are not reset directly; the sweep clears them.
- State CLEAR: each posedge writes 0 to entry[counter] and increments counter.
  - On the posedge that clears entry DEPTH-1, go to READY. busy goes low on that same edge.
  - The sweep takes exactly DEPTH cycles after rst deasserts.
- CLEAR port rules: external writes are dropped, not queued. A port with re[i]=1 loads 0 into rd_i. A port with re[i]=0 holds rd_i.
- State READY: stays in READY until the next rst. There is no other way back to CLEAR.
- Write (READY, we=1): on posedge, entry[wa] <= (entry[wa] & ~wm) | (wd & wm).
  - wm = 0 leaves the entry unchanged.
  - wm = all-ones is a full write.
- Read (READY): latency is 1 cycle. If re[i]=1 at posedge, rd_i <= entry[ra_i]. If re[i]=0, rd_i holds its previous value.
- Each read port is independent. Any number of ports may read the same address in the same cycle.
- Collision (READY, we=1, re[i]=1, ra_i == wa, same edge):
  - BYPASS=1: rd_i <= merged new word, (entry & ~wm) | (wd & wm).
  - BYPASS=0: rd_i <= old entry value.
  - The array is updated in both modes.
- Reset mid-operation: asserting rst at any time aborts pending activity and forces the reset values. The sweep then restarts from entry 0 after release. Writes on the edge where rst is high are lost.
- Addresses: every AW-bit value is legal because DEPTH is a power of two. There is no wrap or out-of-range case.
- No combinational path from any input to rd or busy.

Test Plan:
- Reset sweep (WIDTH=8, DEPTH=4): pulse rst, then release. Required: busy=1 for exactly 4 posedges, then 0. Then read all 4 addresses on port 0: rd0 = 0x00 each.
- Write/read: after busy falls, write wa=2, wd=0x6F (111), wm=0xFF. Next cycle re=2'b11, ra0=2, ra1=2. Required: one cycle later rd0 = rd1 = 0x6F. Then with re=0 for 3 cycles, rd holds 0x6F.
- Masked write: entry1 = 0xAA; write wa=1, wd=0x55, wm=0x0F. Then read address 1. Required: rd0 = 0xA5.
- Collision, BYPASS=1: entry3 = 0x11; on the same edge we=1, wa=3, wd=0x22, wm=0xFF, re0=1, ra0=3. Required: rd0 = 0x22 next cycle.
- Collision, BYPASS=0: same stimulus. Required: rd0 = 0x11, and a following read of address 3 returns 0x22.
- Write during sweep, then reset mid-sweep:
  - Issue we=1, wa=0, wd=0x77 while busy=1. Required: address 0 later reads 0x00, and rd0 reads 0 during the sweep.
  - Assert rst two cycles into a sweep. Required: rd = 0 and busy = 1 immediately, then a full 4-cycle sweep after release.
